// File: rtl/block_fifo_ram3d.sv
// Block FIFO over a P-slot block RAM: whole NP x NB_DATA blocks in, whole blocks out,
// with a registered read port and RD_LAT (1 or 2) cycles from accepted pop to o_rvalid.
module block_fifo_ram3d #(
  parameter int P       = 4,
  parameter int NP      = 1024,
  parameter int NB_DATA = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                            clock,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic                            i_flush,
  input  logic                            i_push,
  input  logic [NP-1:0][NB_DATA-1:0]      i_data,
  output logic                            o_wready,
  input  logic                            i_pop,
  output logic [NP-1:0][NB_DATA-1:0]      o_data,
  output logic                            o_rvalid,
  output logic [$clog2(P+1)-1:0]          o_count,
  output logic                            o_full,
  output logic                            o_empty
);

  localparam int AW = $clog2(P);
  localparam int CW = $clog2(P + 1);

  typedef logic [NP-1:0][NB_DATA-1:0] blk_t;

  blk_t          mem [P];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_acc;
  logic          pop_acc;
  blk_t          data_p0;
  logic          vld_p0;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(P - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // Boundaries come from the pre-edge count, so a full FIFO refuses a push even
  // when a pop frees a slot in the same cycle, and an empty one never bypasses.
  assign o_full   = (o_count == CW'(P));
  assign o_empty  = (o_count == '0);
  assign o_wready = !o_full;
  assign push_acc = i_enable & i_push & !o_full  & !i_flush;
  assign pop_acc  = i_enable & i_pop  & !o_empty & !i_flush;

  always_ff @(posedge clock) begin
    if (push_acc) mem[wptr] <= i_data;
  end

  // Stage 0: pointer/count control and the registered RAM read
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (i_enable) begin
      if (i_flush) begin
        wptr    <= '0;
        rptr    <= '0;
        o_count <= '0;
        vld_p0  <= 1'b0;
      end else begin
        vld_p0 <= pop_acc;
        if (push_acc) wptr <= next_ptr(wptr);
        if (pop_acc) begin
          rptr    <= next_ptr(rptr);
          data_p0 <= mem[rptr];
        end
        if (push_acc && !pop_acc)      o_count <= o_count + CW'(1);
        else if (pop_acc && !push_acc) o_count <= o_count - CW'(1);
      end
    end
  end

  // Stage 1: optional extra output register
  if (RD_LAT == 2) begin : g_lat2
    blk_t data_p1;
    logic vld_p1;

    always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else if (i_enable) begin
        if (i_flush) begin
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end
    end

    assign o_data   = data_p1;
    assign o_rvalid = vld_p1;
  end else begin : g_lat1
    assign o_data   = data_p0;
    assign o_rvalid = vld_p0;
  end

endmodule

// File: tb/tb_block_fifo_ram3d.sv
// Drives one stimulus stream into RD_LAT=1 and RD_LAT=2 instances and scores both
// against a queue-based block FIFO model.
module tb_block_fifo_ram3d;

  typedef logic [3:0][7:0] blk_t;

  logic clock = 1'b0;
  logic i_reset;
  logic i_enable;
  logic i_flush;
  logic i_push;
  logic i_pop;
  blk_t i_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;

    logic       wready;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic [2:0] cnt;
    blk_t       odata;

    blk_t store[$];
    blk_t exp_d[$];
    int   exp_e[$];
    int   edge_n  = 0;
    bit   en_last = 1'b0;

    block_fifo_ram3d #(.P(4), .NP(4), .NB_DATA(8), .RD_LAT(LAT)) dut (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_flush  (i_flush),
      .i_push   (i_push),
      .i_data   (i_data),
      .o_wready (wready),
      .i_pop    (i_pop),
      .o_data   (odata),
      .o_rvalid (rvalid),
      .o_count  (cnt),
      .o_full   (full),
      .o_empty  (empty)
    );

    always @(posedge i_reset) begin
      store.delete();
      exp_d.delete();
      exp_e.delete();
    end

    // Reference: a queue of stored blocks; each popped block is due LAT-1
    // enabled edges after the accepting edge.
    always @(posedge clock) begin : model
      bit pu;
      bit po;
      en_last = i_enable && !i_reset;
      if (!i_reset && i_enable) begin
        edge_n++;
        if (i_flush) begin
          store.delete();
          while (exp_e.size() > 0 && exp_e[$] >= edge_n) begin
            void'(exp_e.pop_back());
            void'(exp_d.pop_back());
          end
        end else begin
          pu = i_push && (store.size() < 4);
          po = i_pop && (store.size() > 0);
          if (po) begin
            exp_d.push_back(store.pop_front());
            exp_e.push_back(edge_n + LAT - 1);
          end
          if (pu) store.push_back(i_data);
        end
      end
    end

    always @(negedge clock) begin : monitor
      bit want_valid;
      check($sformatf("lat%0d count", LAT), 64'(cnt), 64'(store.size()));
      check($sformatf("lat%0d full", LAT), 64'(full), 64'(store.size() == 4));
      check($sformatf("lat%0d empty", LAT), 64'(empty), 64'(store.size() == 0));
      check($sformatf("lat%0d wready", LAT), 64'(wready), 64'(store.size() < 4));
      if (en_last) begin
        want_valid = (exp_e.size() > 0) && (exp_e[0] <= edge_n);
        check($sformatf("lat%0d rvalid edge %0d", LAT, edge_n), 64'(rvalid), 64'(want_valid));
        if (want_valid) begin
          if (rvalid) check($sformatf("lat%0d data", LAT), 64'(odata), 64'(exp_d[0]));
          void'(exp_d.pop_front());
          void'(exp_e.pop_front());
        end
      end
    end
  end

  task automatic step(input bit en, input bit fl, input bit pu, input bit po, input blk_t d);
    i_enable = en;
    i_flush  = fl;
    i_push   = pu;
    i_pop    = po;
    i_data   = d;
    @(negedge clock);
  endtask

  function automatic blk_t rnd();
    return blk_t'($urandom());
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, " lat1 count"}, 64'(lane[0].cnt), 64'd0);
    check({tag, " lat2 count"}, 64'(lane[1].cnt), 64'd0);
    check({tag, " lat1 rvalid"}, 64'(lane[0].rvalid), 64'd0);
    check({tag, " lat2 rvalid"}, 64'(lane[1].rvalid), 64'd0);
    check({tag, " lat1 data"}, 64'(lane[0].odata), 64'd0);
    check({tag, " lat2 data"}, 64'(lane[1].odata), 64'd0);
    check({tag, " lat1 empty"}, 64'(lane[0].empty), 64'd1);
    check({tag, " lat2 wready"}, 64'(lane[1].wready), 64'd1);
  endtask

  initial begin
    blk_t a;
    blk_t b;
    blk_t c;
    a = 32'h04030201;
    b = 32'h14131211;
    c = 32'h24232221;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_flush  = 1'b0;
    i_push   = 1'b0;
    i_pop    = 1'b0;
    i_data   = '0;
    repeat (2) @(negedge clock);
    check_cleared("reset");
    i_reset = 1'b0;

    // In-order push/pop of three known blocks
    step(1, 0, 1, 0, a);
    step(1, 0, 1, 0, b);
    step(1, 0, 1, 0, c);
    repeat (3) step(1, 0, 0, 1, '0);
    repeat (2) step(1, 0, 0, 0, '0);

    // Full: lone push refused, then push+pop lets only the pop through
    repeat (4) step(1, 0, 1, 0, rnd());
    step(1, 0, 1, 0, 32'hDDDDDDDD);
    step(1, 0, 1, 1, 32'hDDDDDDDD);
    repeat (4) step(1, 0, 0, 1, '0);
    repeat (2) step(1, 0, 0, 0, '0);

    // Wrap-around at steady count 2
    repeat (2) step(1, 0, 1, 0, rnd());
    repeat (10) step(1, 0, 1, 1, rnd());
    repeat (3) step(1, 0, 0, 1, '0);
    repeat (2) step(1, 0, 0, 0, '0);

    // Empty with simultaneous push and pop: no bypass
    step(1, 0, 1, 1, 32'hEEEEEEEE);
    step(1, 0, 0, 1, '0);
    repeat (2) step(1, 0, 0, 0, '0);

    // Enable low the cycle after a pop stretches the latency
    step(1, 0, 1, 0, rnd());
    step(1, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    repeat (3) step(1, 0, 0, 0, '0);

    // Flush right after a pop cancels the in-flight read
    repeat (2) step(1, 0, 1, 0, rnd());
    step(1, 0, 0, 1, '0);
    step(1, 1, 1, 1, rnd());
    repeat (2) step(1, 0, 0, 0, '0);

    // Asynchronous reset between edges while data is in flight
    repeat (2) step(1, 0, 1, 0, rnd());
    step(1, 0, 0, 1, '0);
    i_pop = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check_cleared("async reset");
    @(negedge clock);
    i_reset = 1'b0;
    step(1, 0, 0, 0, '0);

    // Randomized traffic with biased fill/drain phases
    for (int i = 0; i < 900; i++) begin
      int bias;
      bias = (i < 300) ? 5 : (i < 600) ? 8 : 2;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < bias, $urandom_range(0, 9) >= bias, rnd());
    end

    repeat (6) step(1, 0, 0, 1, '0);
    repeat (3) step(1, 0, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
